// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART word serializer among N_CH packet sources.
// Emits a header word per packet, then the granted channel's payload words.
module uart_tx_arbiter #(
  parameter int N_CH = 4,
  parameter int CW   = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N_CH-1:0]   CH_REQ,
  input  logic [8*N_CH-1:0] CH_LEN,
  input  logic [16*N_CH-1:0] CH_Q,
  output logic [N_CH-1:0]   CH_RD,
  output logic [N_CH-1:0]   CH_ACK,
  output logic [15:0]       OUT_DATA,
  output logic              OUT_ENA,
  output logic              OUT_LAST_AND_ODD,
  input  logic              OUT_BUSY,
  output logic [CW-1:0]     GRANT,
  output logic              ACTIVE,
  output logic [1:0]        STATE_MON
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CW:0] NCH = (CW+1)'(N_CH);

  state_t          state_q, state_d;
  logic [CW-1:0]   rr_q, rr_d;
  logic [CW-1:0]   grant_q, grant_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      wl_q, wl_d;
  logic [15:0]     data_q, data_d;
  logic            ena_q, ena_d;
  logic            lao_q, lao_d;
  logic [N_CH-1:0] rd_q, rd_d;
  logic [N_CH-1:0] ack_q, ack_d;

  logic [7:0]      len_a [N_CH];
  logic [15:0]     q_a [N_CH];
  logic [N_CH-1:0] grant_oh;
  logic [CW-1:0]   pick;
  logic [CW:0]     idx;
  logic            found;
  logic            issue;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      len_a[i]    = CH_LEN[8*i +: 8];
      q_a[i]      = CH_Q[16*i +: 16];
      grant_oh[i] = (grant_q == CW'(i));
    end
  end

  // Cyclic search for the first requester at or after rr_q
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = {1'b0, rr_q} + (CW+1)'(i);
      if (idx >= NCH) idx = idx - NCH;
      if (!found && CH_REQ[idx[CW-1:0]]) begin
        found = 1'b1;
        pick  = idx[CW-1:0];
      end
    end
  end

  // One guard cycle after every strobe lets the serializer raise BUSY
  assign issue = !OUT_BUSY && !ena_q;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    len_d   = len_q;
    wl_d    = wl_q;
    data_d  = data_q;
    lao_d   = lao_q;
    ena_d   = 1'b0;
    rd_d    = '0;
    ack_d   = '0;
    unique case (state_q)
      IDLE: begin
        // A source still shows REQ during its ACK cycle; skip that cycle
        if (found && ack_q == '0) begin
          grant_d = pick;
          len_d   = len_a[pick];
          wl_d    = 8'(({1'b0, len_a[pick]} + 9'd1) >> 1);
          state_d = HDR;
        end
      end
      HDR: begin
        if (issue) begin
          data_d  = {len_q, 8'hA0 | 8'(grant_q)};
          ena_d   = 1'b1;
          lao_d   = 1'b0;
          state_d = (wl_q == 8'd0) ? DONE : PAY;
        end
      end
      PAY: begin
        if (issue) begin
          data_d = q_a[grant_q];
          ena_d  = 1'b1;
          rd_d   = grant_oh;
          wl_d   = wl_q - 8'd1;
          if (wl_q == 8'd1) begin
            lao_d   = len_q[0];
            state_d = DONE;
          end else begin
            lao_d = 1'b0;
          end
        end
      end
      DONE: begin
        ack_d   = grant_oh;
        rr_d    = (grant_q == CW'(N_CH-1)) ? '0 : grant_q + CW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      len_q   <= '0;
      wl_q    <= '0;
      data_q  <= '0;
      ena_q   <= 1'b0;
      lao_q   <= 1'b0;
      rd_q    <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      len_q   <= len_d;
      wl_q    <= wl_d;
      data_q  <= data_d;
      ena_q   <= ena_d;
      lao_q   <= lao_d;
      rd_q    <= rd_d;
      ack_q   <= ack_d;
    end
  end

  assign OUT_DATA         = data_q;
  assign OUT_ENA          = ena_q;
  assign OUT_LAST_AND_ODD = lao_q;
  assign CH_RD            = rd_q;
  assign CH_ACK           = ack_q;
  assign GRANT            = grant_q;
  assign ACTIVE           = (state_q != IDLE);
  assign STATE_MON        = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: packet table, FIFO and serializer models,
// scoreboard of expected serializer words and ACK order.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic          CLK;
  logic          RST;
  logic [N-1:0]  CH_REQ;
  logic [8*N-1:0] CH_LEN;
  logic [16*N-1:0] CH_Q;
  logic [N-1:0]  CH_RD;
  logic [N-1:0]  CH_ACK;
  logic [15:0]   OUT_DATA;
  logic          OUT_ENA;
  logic          OUT_LAST_AND_ODD;
  logic          OUT_BUSY;
  logic [1:0]    GRANT;
  logic          ACTIVE;
  logic [1:0]    STATE_MON;

  uart_tx_arbiter #(.N_CH(N), .CW(2)) dut (
    .CLK(CLK),
    .RST(RST),
    .CH_REQ(CH_REQ),
    .CH_LEN(CH_LEN),
    .CH_Q(CH_Q),
    .CH_RD(CH_RD),
    .CH_ACK(CH_ACK),
    .OUT_DATA(OUT_DATA),
    .OUT_ENA(OUT_ENA),
    .OUT_LAST_AND_ODD(OUT_LAST_AND_ODD),
    .OUT_BUSY(OUT_BUSY),
    .GRANT(GRANT),
    .ACTIVE(ACTIVE),
    .STATE_MON(STATE_MON)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [15:0] d;
    logic        lao;
    logic [3:0]  rd;
  } exp_t;

  typedef struct {
    int          ch;
    int          len;
    logic [7:0]  seed;
    int          hold;
    logic [15:0] hdr;
  } vec_t;

  exp_t        exp_q[$];
  int          ack_q[$];
  logic [15:0] fifo [N][256];
  int          rdp [N];
  int          wrp [N];
  int          hold;
  int          busy_cnt;
  logic        ena_last;
  int          n_chk;
  int          n_fail;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] pb(input logic [7:0] s, input int k);
    return 8'(s + 8'(8'h11 * k));
  endfunction

  task automatic push_pkt(input int ch, input int len, input logic [7:0] s);
    int   nw;
    exp_t e;
    logic [7:0] hi;
    e.d   = {8'(len), 8'hA0 | 8'(ch)};
    e.lao = 1'b0;
    e.rd  = 4'b0;
    exp_q.push_back(e);
    nw = (len + 1) / 2;
    for (int w = 0; w < nw; w++) begin
      hi = (2*w + 1 < len) ? pb(s, 2*w + 1) : 8'h00;
      fifo[ch][wrp[ch]] = {hi, pb(s, 2*w)};
      e.d   = fifo[ch][wrp[ch]];
      e.lao = (w == nw - 1) && (len % 2 == 1);
      e.rd  = 4'(1 << ch);
      exp_q.push_back(e);
      wrp[ch]++;
    end
    ack_q.push_back(ch);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ack_q.size() != 0 || OUT_BUSY || ACTIVE)
           && n < budget) begin
      @(negedge CLK);
      n++;
    end
    n_chk++;
    if (n >= budget) begin
      n_fail++;
      $display("FAIL timeout: %0d words and %0d acks outstanding after %0d cycles",
               exp_q.size(), ack_q.size(), n);
      exp_q.delete();
      ack_q.delete();
    end
    repeat (2) @(negedge CLK);
  endtask

  // FIFO, serializer and protocol monitor
  always @(negedge CLK) begin
    exp_t e;
    int   a;
    if (!RST) begin
      ena_last = 1'b0;
      busy_cnt = 0;
      OUT_BUSY = 1'b0;
    end else begin
      if (OUT_ENA) begin
        chk("issue_guard", {30'd0, OUT_BUSY, ena_last}, 32'd0);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_ena: got %h expected none", OUT_DATA);
        end else begin
          e = exp_q.pop_front();
          chk("word_data", 32'(OUT_DATA), 32'(e.d));
          chk("word_lao", 32'(OUT_LAST_AND_ODD), 32'(e.lao));
          chk("word_rd", 32'(CH_RD), 32'(e.rd));
        end
      end else if (CH_RD != '0) begin
        n_chk++;
        n_fail++;
        $display("FAIL stray_rd: got %b expected 0", CH_RD);
      end
      if (CH_ACK != '0) begin
        if (ack_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_ack: got %b expected none", CH_ACK);
        end else begin
          a = ack_q.pop_front();
          chk("ack", 32'(CH_ACK), 32'(1 << a));
        end
        CH_REQ = CH_REQ & ~CH_ACK;
      end
      for (int c = 0; c < N; c++)
        if (CH_RD[c]) rdp[c]++;
      ena_last = OUT_ENA;
      if (OUT_ENA) busy_cnt = hold;
      else if (busy_cnt > 0) busy_cnt--;
      OUT_BUSY = (busy_cnt != 0);
    end
    for (int c = 0; c < N; c++)
      CH_Q[16*c +: 16] = fifo[c][rdp[c] % 256];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    int   lat;
    int   n;
    vt[0] = '{2, 5,   8'h11, 0,  16'h05A2};
    vt[1] = '{0, 4,   8'h31, 0,  16'h04A0};
    vt[2] = '{3, 0,   8'h00, 0,  16'h00A3};
    vt[3] = '{1, 3,   8'h61, 20, 16'h03A1};
    vt[4] = '{1, 1,   8'h07, 3,  16'h01A1};
    vt[5] = '{3, 255, 8'h02, 0,  16'hFFA3};

    n_chk = 0;
    n_fail = 0;
    hold = 0;
    busy_cnt = 0;
    ena_last = 1'b0;
    for (int c = 0; c < N; c++) begin
      rdp[c] = 0;
      wrp[c] = 0;
      for (int k = 0; k < 256; k++) fifo[c][k] = 16'h0;
    end
    RST = 1'b0;
    CH_REQ = '0;
    CH_LEN = '0;
    CH_Q = '0;
    OUT_BUSY = 1'b0;

    repeat (3) @(negedge CLK);
    chk("rst_data", 32'(OUT_DATA), 32'd0);
    chk("rst_ctrl", {27'd0, OUT_ENA, OUT_LAST_AND_ODD, ACTIVE, STATE_MON}, 32'd0);
    chk("rst_rd_ack", {24'd0, CH_RD, CH_ACK}, 32'd0);
    chk("rst_grant", 32'(GRANT), 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    chk("idle_state", 32'(STATE_MON), 32'd0);

    for (int i = 0; i < 6; i++) begin
      CH_LEN[8*vt[i].ch +: 8] = 8'(vt[i].len);
      hold = vt[i].hold;
      push_pkt(vt[i].ch, vt[i].len, vt[i].seed);
      CH_REQ[vt[i].ch] = 1'b1;
      lat = 0;
      do begin
        @(negedge CLK);
        lat++;
      end while (!OUT_ENA && lat < 10);
      chk("hdr_latency", 32'(lat), 32'd2);
      chk("hdr_word", 32'(OUT_DATA), 32'(vt[i].hdr));
      wait_done(3000);
    end

    // All four request at once; ch0 re-requests while ch1 is served
    hold = 0;
    CH_LEN = {8'd2, 8'd2, 8'd2, 8'd2};
    push_pkt(0, 2, 8'h81);
    push_pkt(1, 2, 8'h92);
    push_pkt(2, 2, 8'hA3);
    push_pkt(3, 2, 8'hB4);
    push_pkt(0, 2, 8'hC5);
    CH_REQ = 4'hF;
    n = 0;
    while (!(ACTIVE && GRANT == 2'd1) && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("rr_ch1_granted", 32'(n < 100), 32'd1);
    CH_REQ[0] = 1'b1;
    wait_done(500);

    // Reset in the middle of a long payload
    CH_LEN[23:16] = 8'd200;
    push_pkt(2, 200, 8'h5A);
    CH_REQ[2] = 1'b1;
    n = 0;
    while (rdp[2] < 5 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("pay_reached", 32'(STATE_MON), 32'd2);
    #2 RST = 1'b0;
    #1;
    chk("midrst_data", 32'(OUT_DATA), 32'd0);
    chk("midrst_ctrl", {27'd0, OUT_ENA, OUT_LAST_AND_ODD, ACTIVE, STATE_MON}, 32'd0);
    chk("midrst_rd_ack", {24'd0, CH_RD, CH_ACK}, 32'd0);
    exp_q.delete();
    ack_q.delete();
    CH_REQ = '0;
    for (int c = 0; c < N; c++) begin
      rdp[c] = 0;
      wrp[c] = 0;
    end
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("post_rst_idle", {29'd0, ACTIVE, STATE_MON}, 32'd0);
    chk("post_rst_grant", 32'(GRANT), 32'd0);

    // rr_ptr back at 0: ch0 must win over ch3
    CH_LEN[7:0] = 8'd1;
    CH_LEN[31:24] = 8'd1;
    push_pkt(0, 1, 8'hC1);
    push_pkt(3, 1, 8'hD3);
    CH_REQ = 4'b1001;
    wait_done(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
